// File: rtl/wb_result_stage.sv
// Registered writeback result-source mux for the RV32I core.
// It stalls upstream while a load is pending. Define WB_TIMEOUT_EN to add a load-wait timeout with err_o.
module wb_result_stage #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NUM_SRC        = 5,
   parameter int unsigned SEL_WIDTH      = 3,
   parameter int unsigned MEM_SRC_IDX    = 1,
   parameter int unsigned ADDR_WIDTH     = 5,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic [SEL_WIDTH-1:0]          result_src_flag_i,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
   input  logic [ADDR_WIDTH-1:0]         rd_addr_i,
   input  logic                          reg_write_i,
   input  logic                          mem_valid_i,
   output logic [DATA_WIDTH-1:0]         result_o,
   output logic [ADDR_WIDTH-1:0]         rd_addr_o,
   output logic                          reg_write_o,
   output logic                          valid_o,
   output logic                          err_o
);

   typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_e;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pend_rd_q, pend_rd_d;
   logic                   pend_we_q, pend_we_d;
   logic [DATA_WIDTH-1:0]  result_d, sel_word, mem_word;
   logic [ADDR_WIDTH-1:0]  rd_addr_d;
   logic                   reg_write_d, valid_d, err_d;
   logic                   accept, sel_is_mem;

`ifdef WB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`else
   // Timeout length has no meaning when the wait is unbounded.
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

   assign ready_o    = (state_q == IDLE);
   assign accept     = valid_i && ready_o;
   assign sel_is_mem = (result_src_flag_i == SEL_WIDTH'(MEM_SRC_IDX));
   assign mem_word   = src_data_i[MEM_SRC_IDX*DATA_WIDTH +: DATA_WIDTH];

   // Source mux; illegal select codes yield zero.
   always_comb begin
      sel_word = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (result_src_flag_i == SEL_WIDTH'(k)) sel_word = src_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Next state and next output values.
   always_comb begin
      state_d     = state_q;
      result_d    = result_o;
      rd_addr_d   = rd_addr_o;
      reg_write_d = 1'b0;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      pend_rd_d   = pend_rd_q;
      pend_we_d   = pend_we_q;
`ifdef WB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (sel_is_mem && !mem_valid_i) begin
                  state_d   = WAIT_MEM;
                  pend_rd_d = rd_addr_i;
                  pend_we_d = reg_write_i && (rd_addr_i != '0);
`ifdef WB_TIMEOUT_EN
                  cnt_d     = '0;
`endif
               end else begin
                  result_d    = sel_word;
                  rd_addr_d   = rd_addr_i;
                  reg_write_d = reg_write_i && (rd_addr_i != '0);
                  valid_d     = 1'b1;
               end
            end
         end
         WAIT_MEM: begin
            if (mem_valid_i) begin
               result_d    = mem_word;
               rd_addr_d   = pend_rd_q;
               reg_write_d = pend_we_q;
               valid_d     = 1'b1;
               state_d     = IDLE;
            end
`ifdef WB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               result_d = '0;
               valid_d  = 1'b1;
               err_d    = 1'b1;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         pend_rd_q   <= '0;
         pend_we_q   <= 1'b0;
         result_o    <= '0;
         rd_addr_o   <= '0;
         reg_write_o <= 1'b0;
         valid_o     <= 1'b0;
         err_o       <= 1'b0;
`ifdef WB_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         pend_rd_q   <= pend_rd_d;
         pend_we_q   <= pend_we_d;
         result_o    <= result_d;
         rd_addr_o   <= rd_addr_d;
         reg_write_o <= reg_write_d;
         valid_o     <= valid_d;
         err_o       <= err_d;
`ifdef WB_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

endmodule

// File: doc/wb_result_stage.md
Name: wb_result_stage

Overview:
- Parametrised, registered successor to the combinational writeback result-source mux for the RV32I core.
- Selects one of NUM_SRC packed source words and registers the result, destination register and write enable for the register file.
- Stalls the upstream stage through a ready handshake while the memory-read source is still pending, so multi-cycle loads are absorbed.

Parameters:
- DATA_WIDTH, 32, width of each source word and of the result.
- NUM_SRC, 5, number of source channels (0 ALU, 1 memory read, 2 extended imm, 3 PC+4, 4 compare).
- SEL_WIDTH, 3, width of the select input; codes >= NUM_SRC are illegal.
- MEM_SRC_IDX, 1, source index that must wait for mem_valid_i.
- ADDR_WIDTH, 5, destination register address width.
- TIMEOUT_CYCLES, 16, memory wait limit; used only with WB_TIMEOUT_EN.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- valid_i  input  1  upstream request valid.
- ready_o  output  1  stage can accept a request this cycle.
- result_src_flag_i  input  SEL_WIDTH  source select.
- src_data_i  input  NUM_SRC*DATA_WIDTH  packed sources; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- rd_addr_i  input  ADDR_WIDTH  destination register.
- reg_write_i  input  1  request writes the register file.
- mem_valid_i  input  1  channel MEM_SRC_IDX holds valid load data this cycle.
- result_o  output  DATA_WIDTH  registered result.
- rd_addr_o  output  ADDR_WIDTH  registered destination.
- reg_write_o  output  1  one-cycle register-file write strobe.
- valid_o  output  1  one-cycle result-valid pulse.
- err_o  output  1  one-cycle timeout pulse; tied to 0 without WB_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, rst_ni low): state IDLE. result_o, rd_addr_o, reg_write_o, valid_o and err_o are all 0. The timeout counter is 0. ready_o is 1 as soon as rst_ni is released.
- Acceptance: a request is accepted when valid_i && ready_o at a rising edge.
- State IDLE: ready_o = 1.
  - Accept, select != MEM_SRC_IDX: at that edge, result_o <= the selected channel; an illegal select gives 32'd0. rd_addr_o <= rd_addr_i. reg_write_o <= reg_write_i && (rd_addr_i != 0). valid_o <= 1. Latency is 1 cycle.
  - Accept, select == MEM_SRC_IDX, mem_valid_i = 1: same as above, using channel MEM_SRC_IDX. No stall.
  - Accept, select == MEM_SRC_IDX, mem_valid_i = 0: latch rd_addr and reg_write and go to WAIT_MEM. No output strobe.
- State WAIT_MEM: ready_o = 0; valid_i is ignored.
  - On the first edge with mem_valid_i = 1: result_o <= channel MEM_SRC_IDX, rd_addr_o <= latched address, reg_write_o <= latched write && (addr != 0), valid_o <= 1. Return to IDLE.
- Strobe width: valid_o, reg_write_o and err_o are high for exactly one cycle per event and return to 0 on the next edge. result_o and rd_addr_o hold their last value.
- Back-to-back: non-memory requests on consecutive cycles give valid_o every cycle. Throughput is 1 per cycle.
- x0 write: rd_addr 0 gives valid_o = 1 with reg_write_o = 0.
- Reset mid-WAIT_MEM: the pending request is dropped and no strobe is issued.
- mem_valid_i while in IDLE with no request: ignored.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_MEM, cleared on entry.
  - If mem_valid_i is not seen within TIMEOUT_CYCLES cycles in WAIT_MEM, at the TIMEOUT_CYCLES-th edge: err_o <= 1 and valid_o <= 1, result_o <= 0, reg_write_o <= 0. Return to IDLE.
  - If mem_valid_i and expiry occur on the same edge, mem_valid_i wins and no error is flagged.
- Not defined: no counter is built, err_o is constant 0, and WAIT_MEM waits indefinitely.

Test Plan:
- Source values: ALU 100, mem 110, ext 11111, pc+4 11010101, comp 100010001.
- Sel 0,2,3,4 sequentially with valid_i, rd 5, we 1 -> valid_o/reg_write_o each following cycle; result_o = 100, 11111, 11010101, 100010001; rd_addr_o = 5.
- Sel 5,6,7 accepted -> result_o = 0, valid_o = 1.
- Sel 1, mem_valid_i low 3 cycles then high -> ready_o = 0 for 3 cycles; result_o = 110 with valid_o one cycle after mem_valid_i; ready_o = 1 again.
- Sel 0, rd 0, we 1 -> valid_o = 1, reg_write_o = 0, result_o = 100.
- rst_ni pulsed low during WAIT_MEM -> all outputs 0 immediately; no strobe after release.
- WB_TIMEOUT_EN with TIMEOUT_CYCLES = 4, sel 1, mem_valid_i held low -> after 4 cycles err_o = 1, valid_o = 1, result_o = 0, reg_write_o = 0.
